// File: rtl/mem_burst_reader.sv
// mem_burst_reader: streams an inclusive address range out of a synchronous memory
// through a 2-entry output FIFO with valid/ready backpressure.
module mem_burst_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] stop_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cur_addr, stop_q, pend_addr;
  logic              desc, pend, pend_last;
  logic [DATA_W-1:0] fd [2];
  logic [ADDR_W-1:0] fa [2];
  logic [1:0]        fl;
  logic              wp, rp;
  logic [1:0]        cnt;
  logic              pop, rd, last_rd;
  assign out_valid = cnt != 2'd0;
  assign pop       = out_valid && out_ready;
  // A word popped this cycle frees its slot, so back-to-back reads keep one word per cycle.
  assign rd        = state == READ && (cnt - {1'b0, pop} + {1'b0, pend}) < 2'd2;
  assign last_rd   = cur_addr == stop_q;
  assign mem_rd_en = rd;
  assign mem_addr  = cur_addr;
  assign busy      = state != IDLE;
  assign out_data  = out_valid ? fd[rp] : '0;
  assign out_addr  = out_valid ? fa[rp] : '0;
  assign out_last  = out_valid && fl[rp];
  always_comb begin
    state_n = state == IDLE ? (start ? READ : IDLE)
            : state == READ ? (rd && last_rd ? DRAIN : READ)
            : (pop && out_last ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      stop_q    <= '0;
      desc      <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_last <= 1'b0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      cnt       <= 2'd0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == DRAIN && pop && out_last;
      if (state == IDLE && start) begin
        cur_addr <= start_addr;
        stop_q   <= stop_addr;
        desc     <= start_addr > stop_addr;
      end else if (rd && !last_rd) begin
        cur_addr <= desc ? cur_addr - 1'b1 : cur_addr + 1'b1;
      end
      pend      <= rd;
      pend_addr <= cur_addr;
      pend_last <= last_rd;
      if (pend) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, pend} - {1'b0, pop};
    end
  end
  // Storage needs no reset: nothing is visible while cnt is zero.
  always_ff @(posedge clk) begin
    if (pend) begin
      fd[wp] <= mem_rd_data;
      fa[wp] <= pend_addr;
      fl[wp] <= pend_last;
    end
  end
endmodule

// File: doc/mem_burst_reader.md
MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 10, memory address width (1024 locations).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  ADDR_W  first address of burst, inclusive.
REQ-007 SHALL have port stop_addr  input  ADDR_W  last address of burst, inclusive.
REQ-008 SHALL have port busy  output  1  high while not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last output handshake.
REQ-010 SHALL have port mem_rd_en  output  1  read strobe to a synchronous memory.
REQ-011 SHALL have port mem_addr  output  ADDR_W  read address, valid with mem_rd_en.
REQ-012 SHALL have port mem_rd_data  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-013 SHALL have port out_valid  output  1  output word available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts word.
REQ-015 SHALL have port out_data  output  DATA_W  word read from memory.
REQ-016 SHALL have port out_addr  output  ADDR_W  address out_data was read from.
REQ-017 SHALL have port out_last  output  1  marks the final word of the burst, qualified by out_valid.

Function
REQ-018 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on start; READ->DRAIN after last read issued; DRAIN->IDLE on last output handshake.
REQ-019 SHALL latch start_addr/stop_addr on start; direction ascending if start_addr <= stop_addr, else descending.
REQ-020 SHALL transfer |stop_addr - start_addr| + 1 words (1..1024, 11-bit count), no address wrap-around.
REQ-021 SHALL, descending, read start_addr, start_addr-1, ... down to stop_addr.
REQ-022 SHALL assert mem_rd_en first in the cycle after start is sampled, with mem_addr = start_addr.
REQ-023 SHALL buffer read data in a 2-entry in-order output FIFO; issue a read only if FIFO occupancy + in-flight reads < 2.
REQ-024 SHALL present first out_valid 3 cycles after start sampled (start cycle 0, mem_rd_en cycle 1, data cycle 2, out_valid cycle 3).
REQ-025 SHALL sustain one word per cycle when out_ready is held high.
REQ-026 SHALL transfer a word only when out_valid && out_ready; out_data/out_addr/out_last SHALL stay stable while out_valid && !out_ready.
REQ-027 SHALL never drop or duplicate a word under any out_ready pattern.
REQ-028 SHALL ignore start while busy; stop_addr/start_addr changes after latch SHALL have no effect.
REQ-029 SHALL pulse done in the cycle after the last handshake, with busy low in that same cycle; a new start SHALL be accepted in the cycle done is high.
REQ-030 SHALL, when start_addr == stop_addr, transfer exactly one word with out_last high.

Reset
REQ-031 SHALL on rst force state IDLE, busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, FIFO empty.
REQ-032 SHALL on rst mid-burst discard in-flight read data; no out_valid in the cycle after rst deasserts.
REQ-033 SHALL give rst priority over start in the same cycle.

Verification
REQ-034 Ascending: mem[a]=a[7:0], start 4..7, out_ready=1 -> out_data 04,05,06,07 on consecutive cycles, out_last on 07, done next cycle.
REQ-035 Descending: start 200..50 -> 151 words, out_addr 200 down to 50, out_last at 50.
REQ-036 Full range with random out_ready (50%): start 0..1023 -> 1024 words in order, none lost or repeated, outputs stable while stalled.
REQ-037 Single word: start 300..300 -> one word, out_last=1, done pulse.
REQ-038 start pulsed while busy with 9..9 -> ignored; original burst completes unchanged.
REQ-039 rst asserted after 3 words of 0..15 -> all outputs zero next cycle, busy=0; a new start 0..1 then yields 00,01.
